// File: rtl/lct_l1a_win_match_if.sv
// LCT/L1A coincidence bus: strobes and window size in, match/orphan pulses and status out.
// The master side drives the strobes and the slave side is the window matcher.
interface lct_l1a_win_match_if #(
  parameter int WIN_W = 4,
  parameter int CNT_W = 16
);
  logic             LCT_DLY;
  logic             L1A;
  logic [WIN_W-1:0] WIN;
  logic             L1A_MATCH;
  logic             L1A_NOMATCH;
  logic             LCT_ORPHAN;
  logic [WIN_W-1:0] MATCH_POS;
  logic             BUSY;
  logic [CNT_W-1:0] MATCH_CNT;
  logic [CNT_W-1:0] ORPHAN_CNT;

  modport master (
    output LCT_DLY, L1A, WIN,
    input  L1A_MATCH, L1A_NOMATCH, LCT_ORPHAN, MATCH_POS, BUSY, MATCH_CNT, ORPHAN_CNT
  );

  modport slave (
    input  LCT_DLY, L1A, WIN,
    output L1A_MATCH, L1A_NOMATCH, LCT_ORPHAN, MATCH_POS, BUSY, MATCH_CNT, ORPHAN_CNT
  );
endinterface

// File: rtl/lct_l1a_win_match.sv
// Delayed-LCT / L1A coincidence window matcher with registered match, no-match and orphan pulses.
// Optional saturating event counters are built only when LCT_MATCH_CNT_EN is defined.
module lct_l1a_win_match #(
  parameter int WIN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CE,
  lct_l1a_win_match_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1'b1);

  state_t           state_r;
  logic [WIN_W-1:0] pos_r;
  logic [WIN_W-1:0] win_lat_r;
  logic [WIN_W-1:0] match_pos_r;
  logic             match_r;
  logic             nomatch_r;
  logic             orphan_r;
  logic             busy_r;

  logic [WIN_W-1:0] win_eff_s;
  logic [WIN_W-1:0] pos_last_s;
  logic             match_hit_s;
  logic             nomatch_hit_s;
  logic             orphan_hit_s;

  // Effective window size and last valid position of the open window.
  always_comb begin
    win_eff_s  = bus.WIN;
    pos_last_s = win_lat_r - WIN_ONE;
    if (bus.WIN == WIN_ZERO) begin
      win_eff_s = WIN_ONE;
    end else begin
      win_eff_s = bus.WIN;
    end
  end

  // Qualify this cycle's events; CE low suppresses every event so the counters freeze too.
  always_comb begin
    match_hit_s   = 1'b0;
    nomatch_hit_s = 1'b0;
    orphan_hit_s  = 1'b0;
    if (CE) begin
      case (state_r)
        IDLE: begin
          match_hit_s   = bus.LCT_DLY && bus.L1A;
          nomatch_hit_s = !bus.LCT_DLY && bus.L1A;
          orphan_hit_s  = bus.LCT_DLY && !bus.L1A && (win_eff_s == WIN_ONE);
        end
        OPEN: begin
          match_hit_s   = bus.L1A;
          nomatch_hit_s = 1'b0;
          orphan_hit_s  = !bus.L1A && (pos_r == pos_last_s);
        end
        default: begin
          match_hit_s   = 1'b0;
          nomatch_hit_s = 1'b0;
          orphan_hit_s  = 1'b0;
        end
      endcase
    end else begin
      match_hit_s   = 1'b0;
      nomatch_hit_s = 1'b0;
      orphan_hit_s  = 1'b0;
    end
  end

  // Window FSM with registered pulses; pos_r stays 0 in IDLE so a same-cycle match reports 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      pos_r       <= WIN_ZERO;
      win_lat_r   <= WIN_ZERO;
      match_pos_r <= WIN_ZERO;
      match_r     <= 1'b0;
      nomatch_r   <= 1'b0;
      orphan_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      match_r   <= match_hit_s;
      nomatch_r <= nomatch_hit_s;
      orphan_r  <= orphan_hit_s;
      if (match_hit_s) begin
        match_pos_r <= pos_r;
      end
      if (CE) begin
        case (state_r)
          IDLE: begin
            if (bus.LCT_DLY && !bus.L1A) begin
              win_lat_r <= win_eff_s;
              if (win_eff_s != WIN_ONE) begin
                state_r <= OPEN;
                pos_r   <= WIN_ONE;
                busy_r  <= 1'b1;
              end
            end
          end
          OPEN: begin
            // A new LCT while open is ignored, including one arriving on the closing cycle.
            if (match_hit_s || orphan_hit_s) begin
              state_r <= IDLE;
              pos_r   <= WIN_ZERO;
              busy_r  <= 1'b0;
            end else begin
              pos_r <= pos_r + WIN_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            pos_r   <= WIN_ZERO;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.L1A_MATCH   = match_r;
  assign bus.L1A_NOMATCH = nomatch_r;
  assign bus.LCT_ORPHAN  = orphan_r;
  assign bus.MATCH_POS   = match_pos_r;
  assign bus.BUSY        = busy_r;

`ifdef LCT_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt_r;
  logic [CNT_W-1:0] orphan_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  // Saturating event counters, updated in the same edge that registers the pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      match_cnt_r  <= {CNT_W{1'b0}};
      orphan_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (match_hit_s) begin
        match_cnt_r <= sat_inc(match_cnt_r);
      end
      if (orphan_hit_s) begin
        orphan_cnt_r <= sat_inc(orphan_cnt_r);
      end
    end
  end

  assign bus.MATCH_CNT  = match_cnt_r;
  assign bus.ORPHAN_CNT = orphan_cnt_r;
`else
  assign bus.MATCH_CNT  = {CNT_W{1'b0}};
  assign bus.ORPHAN_CNT = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lct_l1a_win_match.sv
// Scoreboard bench for lct_l1a_win_match: directed LCT/L1A sequences, expected pulses queued
// with their due cycle and checked by an independent monitor on the falling edge.
module tb_lct_l1a_win_match;

  localparam int WIN_W = 4;
  localparam int CNT_W = 4;
  localparam logic [2:0] K_MATCH   = 3'b100;
  localparam logic [2:0] K_NOMATCH = 3'b010;
  localparam logic [2:0] K_ORPHAN  = 3'b001;

  typedef struct {
    logic [2:0]       kind;
    logic [WIN_W-1:0] pos;
    int               due;
  } exp_t;

  logic CLK;
  logic RST_N;
  logic CE;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_mcnt;
  int   exp_ocnt;
  exp_t sb_q[$];

  lct_l1a_win_match_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  lct_l1a_win_match #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc_in(input logic lct, input logic l1a);
    bus.LCT_DLY = lct;
    bus.L1A     = l1a;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_in(1'b0, 1'b0);
  endtask

  task automatic push(input logic [2:0] kind, input logic [WIN_W-1:0] pos, input int due);
    exp_t e;
    e.kind = kind;
    e.pos  = pos;
    e.due  = due;
    sb_q.push_back(e);
    if (kind == K_MATCH && exp_mcnt < 15) exp_mcnt++;
    if (kind == K_ORPHAN && exp_ocnt < 15) exp_ocnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int cnt_exp(input int model);
`ifdef LCT_MATCH_CNT_EN
    return model;
`else
    return 0;
`endif
  endfunction

  // Monitor: every presented pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    logic [2:0] pv;
    exp_t       e;
    pv = {bus.L1A_MATCH, bus.L1A_NOMATCH, bus.LCT_ORPHAN};
    if (pv != 3'b000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=%b expected=none cyc=%0d", pv, cyc);
      end else begin
        e = sb_q.pop_front();
        if (pv !== e.kind || cyc != e.due || (e.kind == K_MATCH && bus.MATCH_POS !== e.pos)) begin
          errors++;
          $display("FAIL pulse actual=%b/pos%0d/cyc%0d expected=%b/pos%0d/cyc%0d",
                   pv, bus.MATCH_POS, cyc, e.kind, e.pos, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0; exp_mcnt = 0; exp_ocnt = 0;
    RST_N = 1'b0; CE = 1'b1;
    bus.LCT_DLY = 1'b0; bus.L1A = 1'b0; bus.WIN = 4'd4;
    idle(3);
    chk("reset_busy", bus.BUSY, 0);
    chk("reset_match_pos", bus.MATCH_POS, 0);
    chk("reset_pulses", {bus.L1A_MATCH, bus.L1A_NOMATCH, bus.LCT_ORPHAN}, 0);
    chk("reset_match_cnt", bus.MATCH_CNT, 0);
    RST_N = 1'b1;
    idle(2);

    // WIN=4, L1A two cycles after LCT -> match at pos 2
    cyc_in(1'b1, 1'b0);
    chk("t1_busy_pos1", bus.BUSY, 1);
    cyc_in(1'b0, 1'b0);
    chk("t1_busy_pos2", bus.BUSY, 1);
    push(K_MATCH, 4'd2, cyc + 1);
    cyc_in(1'b0, 1'b1);
    chk("t1_busy_closed", bus.BUSY, 0);
    chk("t1_match_pos", bus.MATCH_POS, 2);
    idle(3);

    // WIN=4, no L1A -> orphan four edges after the LCT edge
    push(K_ORPHAN, 4'd0, cyc + 4);
    cyc_in(1'b1, 1'b0);
    idle(2);
    chk("t2_busy_last", bus.BUSY, 1);
    idle(1);
    chk("t2_busy_after_expiry", bus.BUSY, 0);
    idle(2);

    // L1A with LCT -> match at pos 0, no window
    push(K_MATCH, 4'd0, cyc + 1);
    cyc_in(1'b1, 1'b1);
    chk("t3_busy_never", bus.BUSY, 0);
    chk("t3_match_pos0", bus.MATCH_POS, 0);
    idle(1);
    // L1A on last window cycle -> match at pos 3, not an orphan
    cyc_in(1'b1, 1'b0);
    idle(2);
    push(K_MATCH, 4'd3, cyc + 1);
    cyc_in(1'b0, 1'b1);
    chk("t3_match_pos3", bus.MATCH_POS, 3);
    idle(4);

    // WIN=0 behaves as 1: immediate orphan; lone L1A -> no-match
    bus.WIN = 4'd0;
    push(K_ORPHAN, 4'd0, cyc + 1);
    cyc_in(1'b1, 1'b0);
    chk("t4_busy_win0", bus.BUSY, 0);
    idle(1);
    push(K_NOMATCH, 4'd0, cyc + 1);
    cyc_in(1'b0, 1'b1);
    idle(2);

    // WIN=8, second LCT ignored, WIN change mid-window ignored, L1A at pos 5
    bus.WIN = 4'd8;
    cyc_in(1'b1, 1'b0);
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b0);
    bus.WIN = 4'd2;
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b0, 1'b0);
    push(K_MATCH, 4'd5, cyc + 1);
    cyc_in(1'b0, 1'b1);
    chk("t5_match_pos5", bus.MATCH_POS, 5);
    bus.WIN = 4'd8;
    idle(3);
    // Reset mid-window aborts silently
    cyc_in(1'b1, 1'b0);
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b0);
    RST_N = 1'b0;
    exp_mcnt = 0;
    exp_ocnt = 0;
    cyc_in(1'b0, 1'b0);
    chk("t5_reset_busy", bus.BUSY, 0);
    chk("t5_reset_match_pos", bus.MATCH_POS, 0);
    RST_N = 1'b1;
    idle(10);

    // WIN=2: LCT on the expiry cycle is dropped, one orphan only
    bus.WIN = 4'd2;
    push(K_ORPHAN, 4'd0, cyc + 2);
    cyc_in(1'b1, 1'b0);
    cyc_in(1'b1, 1'b0);
    chk("t6_busy_dropped", bus.BUSY, 0);
    idle(4);

    // CE low freezes the window and suppresses pulses
    bus.WIN = 4'd4;
    push(K_ORPHAN, 4'd0, cyc + 6);
    cyc_in(1'b1, 1'b0);
    CE = 1'b0;
    cyc_in(1'b0, 1'b1);
    chk("t7_ce_busy_hold", bus.BUSY, 1);
    cyc_in(1'b0, 1'b0);
    CE = 1'b1;
    idle(5);
    CE = 1'b0;
    cyc_in(1'b0, 1'b1);
    cyc_in(1'b1, 1'b1);
    CE = 1'b1;
    idle(2);
    chk("t7_match_cnt_frozen", bus.MATCH_CNT, cnt_exp(exp_mcnt));
    chk("t7_orphan_cnt", bus.ORPHAN_CNT, cnt_exp(exp_ocnt));

    // 17 back-to-back same-cycle matches saturate the match counter
    for (int i = 0; i < 17; i++) begin
      push(K_MATCH, 4'd0, cyc + 1);
      cyc_in(1'b1, 1'b1);
    end
    idle(3);
    chk("sat_match_cnt", bus.MATCH_CNT, cnt_exp(exp_mcnt));
    chk("sat_orphan_cnt", bus.ORPHAN_CNT, cnt_exp(exp_ocnt));

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lct_l1a_win_match.md
Name: lct_l1a_win_match

Overview:
- Consumes the delayed LCT strobe from the programmable SRL delay line and checks it against incoming L1A in a programmable coincidence window.
- Issues registered match, no-match and orphan pulses for the L1A/readout logic, plus the window position at which the match occurred.
- Sits directly downstream of the LCT delay stage; all logic runs in the DAQ clock domain.

Parameters:
- WIN_W, 4, width of window-size input and position counter (max window 2^WIN_W - 1 clocks)
- CNT_W, 16, width of optional event counters

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  synchronous reset, active-low
- CE  in  1  clock enable; when low all state holds and output pulses are forced 0
- LCT_DLY  in  1  delayed LCT strobe (one cycle per LCT)
- L1A  in  1  level-1 accept strobe (one cycle per L1A)
- WIN  in  WIN_W  window width in clocks; 0 treated as 1; sampled only when a window opens
- L1A_MATCH  out  1  one-cycle pulse: L1A fell inside an open window
- L1A_NOMATCH  out  1  one-cycle pulse: L1A with no window open
- LCT_ORPHAN  out  1  one-cycle pulse: window expired without L1A
- MATCH_POS  out  WIN_W  window position of last match (0 = LCT cycle); held until next match
- BUSY  out  1  window open (state OPEN)
- MATCH_CNT  out  CNT_W  matches, saturating (feature only)
- ORPHAN_CNT  out  CNT_W  orphans, saturating (feature only)

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (RST_N=0 at a CLK edge): state IDLE, pos=0, win_lat=0; L1A_MATCH, L1A_NOMATCH, LCT_ORPHAN, BUSY=0; MATCH_POS=0; counters=0. Reset mid-window aborts the window and emits no orphan.
- Latency: all outputs registered. A pulse appears in the cycle after the qualifying input edge.
- FSM has two states, IDLE and OPEN. pos counts the cycles since LCT_DLY; the LCT cycle is pos 0.
- IDLE, LCT_DLY=1 and L1A=1: match at pos 0. L1A_MATCH=1, MATCH_POS=0. Stay IDLE.
- IDLE, LCT_DLY=1 and L1A=0: latch win_lat = max(WIN,1).
  - If win_lat==1: LCT_ORPHAN=1, stay IDLE.
  - Otherwise: go to OPEN with pos=1.
- IDLE, L1A=1 and LCT_DLY=0: L1A_NOMATCH=1.
- OPEN, L1A=1: L1A_MATCH=1, MATCH_POS=pos, go to IDLE.
- OPEN, L1A=0 and pos==win_lat-1: LCT_ORPHAN=1, go to IDLE.
- OPEN, L1A=0 and pos<win_lat-1: pos++.
- OPEN, LCT_DLY=1: the new LCT is ignored. Windows never overlap and no orphan is reported for the ignored LCT. A second L1A inside the same window cannot occur because the first L1A closes it.
- Boundary: an L1A on the last window cycle (pos==win_lat-1) is a match, not an orphan.
- Boundary: LCT_DLY in the cycle OPEN closes (match or expiry) is dropped. Re-arm happens only from IDLE.
- WIN changes while OPEN have no effect until the next window opens.
- CE=0: FSM, pos and counters freeze; output pulses are 0; MATCH_POS and BUSY hold.
- Counters increment by 1 with each corresponding pulse and saturate at all-ones (no wrap).

Optional Feature:
- Macro: LCT_MATCH_CNT_EN.
- Defined: MATCH_CNT and ORPHAN_CNT are implemented as saturating CNT_W counters, cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesised. Port list is unchanged.

Test Plan:
- Reset, WIN=4, LCT_DLY pulse at cycle 10, L1A at cycle 12 -> L1A_MATCH=1 at cycle 13, MATCH_POS=2, BUSY high cycles 11-12, no orphan.
- WIN=4, LCT_DLY at cycle 10, no L1A -> LCT_ORPHAN=1 at cycle 14 (pos 3 expiry at 13), BUSY low from 14.
- WIN=4, L1A on the same cycle as LCT_DLY -> L1A_MATCH next cycle, MATCH_POS=0, BUSY never set. Repeat with L1A at pos 3 -> match, MATCH_POS=3, no orphan.
- WIN=0, LCT_DLY alone -> LCT_ORPHAN the next cycle. L1A alone in IDLE -> L1A_NOMATCH the next cycle.
- WIN=8, LCT_DLY at cycle 10 and again at 12, L1A at 15 -> exactly one match with MATCH_POS=5; RST_N=0 at 13 in a second run -> no pulses, BUSY=0 at 14.
- With LCT_MATCH_CNT_EN and CNT_W=4: drive 17 matches -> MATCH_CNT=15 (saturated). CE=0 during an L1A -> no pulse and counter unchanged.
